// File: rtl/seq_det_param.sv
// seq_det_param: parametrised Moore serial pattern detector.
//
// Bits on in_seq are sampled only when in_valid is high. They are compared
// against a reloadable pattern register. The MSB of the pattern is the first
// bit received. Matching can overlap or not, selected by ovl_en.
// det_out is a one-cycle registered pulse on the cycle after the edge that
// samples the last pattern bit. match_cnt counts matches and saturates.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_seq     serial data bit
//   in_valid   qualifies in_seq
//   ovl_en     1 = overlapping detection, 0 = non-overlapping
//   pat_in     new pattern value (PAT_LEN bits)
//   pat_ld     loads pat_in and restarts detection
//   cnt_clr    synchronous clear of match_cnt (wins over a coincident match)
//   det_out    registered detect pulse
//   match_cnt  saturating match counter (CNT_W bits)
module seq_det_param #(
    parameter int unsigned        PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b111010,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_seq,
    input  logic               in_valid,
    input  logic               ovl_en,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               pat_ld,
    input  logic               cnt_clr,
    output logic               det_out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned         FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_LEN);
    // One bit short of a full pattern: the incoming bit completes it.
    localparam logic [FILL_W-1:0]   FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
        $error("seq_det_param: PAT_LEN must be in 2..32");
    end

    logic [PAT_LEN-1:0] pat_reg;
    // Only the newest PAT_LEN-1 bits are kept: together with the bit being
    // sampled they form the full comparison window, so an older bit would
    // never be looked at.
    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] window;
    logic               match;

    assign window = {hist, in_seq};
    assign match  = in_valid & ~pat_ld & (fill >= FILL_ARM) & (window == pat_reg);

    // Pattern, history and fill level. A load discards any coincident bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_ld) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
        end else if (in_valid) begin
            hist <= window[PAT_LEN-2:0];
            // Non-overlap restarts the fill so the next match needs a full
            // fresh pattern; overlap keeps fill saturated so a self-overlapping
            // suffix can finish the next match.
            if (match && !ovl_en)
                fill <= '0;
            else if (fill != FILL_FULL)
                fill <= fill + 1'b1;
        end
    end

    // match already folds in in_valid and pat_ld, so idle and load cycles
    // drive det_out low on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            det_out <= 1'b0;
        else
            det_out <= match;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            match_cnt <= '0;
        else if (cnt_clr)
            match_cnt <= '0;
        else if (match && match_cnt != CNT_MAX)
            match_cnt <= match_cnt + 1'b1;
    end

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed bench for seq_det_param.
//
// Three instances share one stimulus stream:
//   u0: default (PAT_LEN=6, 111010, CNT_W=8)
//   u1: PAT_LEN=4, 1010, CNT_W=8
//   u2: PAT_LEN=6, 111010, CNT_W=2
// A list-based model keeps every bit received since the last restart. It
// declares a match when the newest PAT_LEN bits spell the pattern. It is
// compared with all outputs on every cycle. Directed steps also pin
// literal values.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_seq = 1'b0, in_valid = 1'b0, ovl_en = 1'b1;
    logic       pat_ld = 1'b0, cnt_clr = 1'b0;
    logic [5:0] pat_in6 = 6'b111010;
    logic [3:0] pat_in4 = 4'b1010;
    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_det_param u0 (
        .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid), .ovl_en(ovl_en),
        .pat_in(pat_in6), .pat_ld(pat_ld), .cnt_clr(cnt_clr), .det_out(det0), .match_cnt(cnt0));

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid), .ovl_en(ovl_en),
        .pat_in(pat_in4), .pat_ld(pat_ld), .cnt_clr(cnt_clr), .det_out(det1), .match_cnt(cnt1));

    seq_det_param #(.PAT_LEN(6), .PATTERN(6'b111010), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid), .ovl_en(ovl_en),
        .pat_in(pat_in6), .pat_ld(pat_ld), .cnt_clr(cnt_clr), .det_out(det2), .match_cnt(cnt2));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          plen[3] = '{6, 4, 6};
    int          cmax[3] = '{255, 255, 3};
    logic [31:0] mpat[3];
    bit          mbits[3][64];
    int          mlen[3];
    bit          exp_det[3];
    int          exp_cnt[3];

    function automatic bit tail_hit(input int i);
        if (mlen[i] < plen[i]) return 1'b0;
        for (int k = 0; k < plen[i]; k++)
            if (mbits[i][mlen[i] - plen[i] + k] != mpat[i][plen[i] - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                mpat[i]    = (i == 1) ? 32'hA : 32'h3A;
                mlen[i]    = 0;
                exp_det[i] = 1'b0;
                exp_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit hit;
                hit = 1'b0;
                if (pat_ld) begin
                    mpat[i] = (i == 1) ? {28'b0, pat_in4} : {26'b0, pat_in6};
                    mlen[i] = 0;
                end else if (in_valid) begin
                    if (mlen[i] == 64) begin
                        for (int k = 0; k < 63; k++) mbits[i][k] = mbits[i][k+1];
                        mlen[i] = 63;
                    end
                    mbits[i][mlen[i]] = in_seq;
                    mlen[i]++;
                    hit = tail_hit(i);
                    if (hit && !ovl_en) mlen[i] = 0;
                end
                exp_det[i] = hit;
                if (cnt_clr) exp_cnt[i] = 0;
                else if (hit && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("det_u0", det0, exp_det[0]);
            chk("det_u1", det1, exp_det[1]);
            chk("det_u2", det2, exp_det[2]);
            chk("cnt_u0", cnt0, exp_cnt[0]);
            chk("cnt_u1", cnt1, exp_cnt[1]);
            chk("cnt_u2", cnt2, exp_cnt[2]);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic det_of(input int inst);
        case (inst)
            0:       return det0;
            1:       return det1;
            default: return det2;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic b);
        in_valid = v;
        in_seq   = b;
        @(negedge clk);
    endtask

    // Sends n bits MSB first; checks det of one instance after each bit.
    task automatic send_chk(input string nm, input logic [31:0] bits,
                            input logic [31:0] exp, input int n, input int inst);
        for (int k = n - 1; k >= 0; k--) begin
            cyc(1'b1, bits[k]);
            chk(nm, det_of(inst), exp[k]);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        pat_ld   = 1'b0;
        cnt_clr  = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_det", det0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_cnt2", cnt2, 0);
        rst    = 1'b1;
        ovl_en = 1'b1;

        // 1: basic detect
        send_chk("t1_det", 6'b111010, 6'b000001, 6, 0);
        chk("t1_cnt", cnt0, 1);
        cyc(1'b0, 1'b0);
        chk("t1_after", det0, 0);

        // 2: leading extra 1, then a near miss
        do_reset();
        send_chk("t2a_det", 7'b1111010, 7'b0000001, 7, 0);
        send_chk("t2b_det", 5'b11010, 5'b00000, 5, 0);
        chk("t2_cnt", cnt0, 1);

        // 3: 1010 overlapping vs non-overlapping on the 4-bit instance
        do_reset();
        send_chk("t3o_det", 8'b10101010, 8'b00010101, 8, 1);
        chk("t3o_cnt", cnt1, 3);
        do_reset();
        ovl_en = 1'b0;
        send_chk("t3n_det", 8'b10101010, 8'b00010001, 8, 1);
        chk("t3n_cnt", cnt1, 2);
        ovl_en = 1'b1;

        // 4: idle gap inside the pattern
        do_reset();
        send_chk("t4a_det", 3'b111, 3'b000, 3, 0);
        repeat (3) begin
            cyc(1'b0, 1'b1);
            chk("t4_gap", det0, 0);
        end
        send_chk("t4b_det", 3'b010, 3'b001, 3, 0);
        chk("t4_cnt", cnt0, 1);

        // 5: asynchronous reset mid-stream
        do_reset();
        send_chk("t5a_det", 6'b111010, 6'b000001, 6, 0);
        send_chk("t5b_det", 5'b11101, 5'b00000, 5, 0);
        chk("t5_cnt_pre", cnt0, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_det", det0, 0);
        chk("t5_rst_cnt", cnt0, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        send_chk("t5c_det", 1'b0, 1'b0, 1, 0);
        chk("t5_cnt_post", cnt0, 0);

        // 6a: runtime pattern load; coincident valid bit is discarded
        do_reset();
        pat_in6 = 6'b000111;
        pat_ld  = 1'b1;
        cyc(1'b1, 1'b1);
        pat_ld  = 1'b0;
        chk("t6_ld_det", det0, 0);
        send_chk("t6_old", 6'b111010, 6'b000000, 6, 0);
        send_chk("t6_new", 6'b000111, 6'b000001, 6, 0);
        chk("t6_ld_cnt", cnt0, 1);

        // 6b: counter saturation on CNT_W=2
        do_reset();
        repeat (5) send_chk("t6s_det", 6'b111010, 6'b000001, 6, 2);
        chk("t6s_cnt2", cnt2, 3);
        chk("t6s_cnt0", cnt0, 5);

        // 6c: clear coincident with a match
        send_chk("t6c_pre", 5'b11101, 5'b00000, 5, 0);
        cnt_clr = 1'b1;
        cyc(1'b1, 1'b0);
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        chk("t6c_det", det0, 1);
        chk("t6c_cnt0", cnt0, 0);
        chk("t6c_cnt2", cnt2, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
